// File: rtl/roe_sequencer_pkg.sv
// Shared definitions for the R.O.E fetch/execute sequencer.
//   op_code_t   : major opcode held in ir[8:6]
//   func_code_t : sub-function held in ir[5:4] when the opcode is OP_HARD
//   seq_state_t : sequencer states
//   HALT_INSTR_DEFAULT : encoding that stops the core
package roe_sequencer_pkg;

   typedef enum logic [2:0] {
      OP_REG   = 3'd0,
      OP_ARITH = 3'd1,
      OP_SHIFT = 3'd2,
      OP_HARD  = 3'd3,
      OP_SLT   = 3'd4,
      OP_XOR   = 3'd5,
      OP_AND   = 3'd6,
      OP_OR    = 3'd7
   } op_code_t;

   typedef enum logic [1:0] {
      FN_REDEF  = 2'd0,
      FN_LW     = 2'd1,
      FN_SW     = 2'd2,
      FN_BRANCH = 2'd3
   } func_code_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      EXEC  = 3'd2,
      MEM   = 3'd3,
      WB    = 3'd4,
      HALT  = 3'd5
   } seq_state_t;

   localparam logic [8:0] HALT_INSTR_DEFAULT = 9'h1FF;

endpackage

// File: rtl/roe_sequencer.sv
// Multi-cycle fetch/execute sequencer for the R.O.E core.
// Fetches an instruction over the imem req/valid handshake into IR, then steps
// it through EXEC / MEM / WB, producing the PC, register-file and data-memory
// strobes. The strobes are combinational decodes of state, IR and inputs;
// state, IR, the dmem timeout counter, the retired counter and fault are
// registered.
// Ports:
//   clk, reset        clock (rising edge) and asynchronous active-high reset
//   start             leave IDLE and begin fetching
//   instr, imem_valid instruction read data and its valid strobe
//   dmem_ack          data-memory access complete
//   branch_taken      branch condition, sampled in EXEC
//   imem_req          instruction fetch request
//   ir                held instruction register (feeds the control decoder)
//   pc_inc, pc_load   PC increment / PC load-branch-target strobes
//   dmem_req, dmem_we data-memory request and store select
//   rf_we             register-file write strobe
//   busy, halted      running / stopped status
//   fault             sticky dmem timeout flag
//   retired           saturating count of completed instructions
module roe_sequencer
   import roe_sequencer_pkg::*;
#(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter logic [8:0]  HALT_INSTR  = HALT_INSTR_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [8:0]       instr,
   input  logic             imem_valid,
   input  logic             dmem_ack,
   input  logic             branch_taken,
   output logic             imem_req,
   output logic [8:0]       ir,
   output logic             pc_inc,
   output logic             pc_load,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             rf_we,
   output logic             busy,
   output logic             halted,
   output logic             fault,
   output logic [CNT_W-1:0] retired
);

   // The timeout counter only has to reach MEM_TIMEOUT-1.
   localparam int unsigned     TMO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

   seq_state_t       state;
   seq_state_t       state_nxt;
   logic [TMO_W-1:0] tmo;
   logic             retire;
   logic             fault_set;
   logic             tmo_clear;
   logic             tmo_inc;

   op_code_t   op;
   func_code_t fun2;
   logic       is_halt;
   logic       is_lw;
   logic       is_sw;
   logic       is_branch;

   assign op        = op_code_t'(ir[8:6]);
   assign fun2      = func_code_t'(ir[5:4]);
   assign is_halt   = (ir == HALT_INSTR);
   assign is_lw     = (op == OP_HARD) && (fun2 == FN_LW);
   assign is_sw     = (op == OP_HARD) && (fun2 == FN_SW);
   assign is_branch = (op == OP_HARD) && (fun2 == FN_BRANCH);

   assign busy   = (state != IDLE) && (state != HALT);
   assign halted = (state == HALT);

   always_comb begin
      state_nxt = state;
      imem_req  = 1'b0;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      rf_we     = 1'b0;
      retire    = 1'b0;
      fault_set = 1'b0;
      tmo_clear = 1'b0;
      tmo_inc   = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = FETCH;
         end
         FETCH: begin
            imem_req = 1'b1;
            if (imem_valid) state_nxt = EXEC;
         end
         EXEC: begin
            // The halt encoding is checked before any opcode decode.
            if (is_halt) begin
               state_nxt = HALT;
            end else if (is_lw || is_sw) begin
               tmo_clear = 1'b1;
               state_nxt = MEM;
            end else if (is_branch) begin
               pc_load   = branch_taken;
               pc_inc    = ~branch_taken;
               retire    = 1'b1;
               state_nxt = FETCH;
            end else begin
               state_nxt = WB;
            end
         end
         MEM: begin
            dmem_req = 1'b1;
            dmem_we  = is_sw;
            // An ack arriving on the last allowed cycle still completes the access.
            if (dmem_ack) begin
               if (is_sw) begin
                  pc_inc    = 1'b1;
                  retire    = 1'b1;
                  state_nxt = FETCH;
               end else begin
                  state_nxt = WB;
               end
            end else if (tmo == TMO_LAST) begin
               fault_set = 1'b1;
               state_nxt = HALT;
            end else begin
               tmo_inc = 1'b1;
            end
         end
         WB: begin
            rf_we     = 1'b1;
            pc_inc    = 1'b1;
            retire    = 1'b1;
            state_nxt = FETCH;
         end
         HALT: begin
            state_nxt = HALT;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         ir      <= '0;
         tmo     <= '0;
         fault   <= 1'b0;
         retired <= '0;
      end else begin
         state <= state_nxt;
         if ((state == FETCH) && imem_valid) ir <= instr;
         if (tmo_clear)    tmo <= '0;
         else if (tmo_inc) tmo <= tmo + TMO_W'(1);
         if (fault_set) fault <= 1'b1;
         // Saturate rather than wrap once the counter is all-ones.
         if (retire && (retired != {CNT_W{1'b1}})) retired <= retired + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_roe_sequencer.sv
// Scoreboard bench for roe_sequencer. The driver plays imem/dmem, and for each
// instruction issued pushes the expected completion event (strobes, cycle,
// retired count) derived from the instruction-level latency rules. A separate
// monitor pops and compares whenever the DUT shows a completion strobe or halts.
// A second instance with CNT_W=2 shares the stimulus to exercise saturation.
module tb_roe_sequencer;

   localparam int         MT     = 15;
   localparam int         CW     = 16;
   localparam int         MAXC   = (1 << CW) - 1;
   localparam logic [8:0] HALT_I = 9'h1FF;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [8:0]    instr;
   logic          imem_valid;
   logic          dmem_ack;
   logic          branch_taken;

   logic          imem_req, pc_inc, pc_load, dmem_req, dmem_we, rf_we, busy, halted, fault;
   logic [8:0]    ir;
   logic [CW-1:0] retired;

   logic          s_imem_req, s_pc_inc, s_pc_load, s_dmem_req, s_dmem_we, s_rf_we;
   logic          s_busy, s_halted, s_fault;
   logic [8:0]    s_ir;
   logic [1:0]    s_retired;

   roe_sequencer #(.CNT_W(CW), .MEM_TIMEOUT(MT), .HALT_INSTR(HALT_I)) u_dut (
      .clk(clk), .reset(reset), .start(start), .instr(instr), .imem_valid(imem_valid),
      .dmem_ack(dmem_ack), .branch_taken(branch_taken), .imem_req(imem_req), .ir(ir),
      .pc_inc(pc_inc), .pc_load(pc_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .rf_we(rf_we), .busy(busy), .halted(halted), .fault(fault), .retired(retired)
   );

   roe_sequencer #(.CNT_W(2), .MEM_TIMEOUT(MT), .HALT_INSTR(HALT_I)) u_sat (
      .clk(clk), .reset(reset), .start(start), .instr(instr), .imem_valid(imem_valid),
      .dmem_ack(dmem_ack), .branch_taken(branch_taken), .imem_req(s_imem_req), .ir(s_ir),
      .pc_inc(s_pc_inc), .pc_load(s_pc_load), .dmem_req(s_dmem_req), .dmem_we(s_dmem_we),
      .rf_we(s_rf_we), .busy(s_busy), .halted(s_halted), .fault(s_fault), .retired(s_retired)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         halt;
      bit         fault;
      bit         rf_we;
      bit         pc_inc;
      bit         pc_load;
      bit         is_sw;
      logic [8:0] ins;
      int         due;
      int         ret;
      int         ret2;
   } exp_t;

   exp_t q[$];
   int   mcnt  = 0;
   int   mcnt2 = 0;
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
      tests++;
      if (got !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s: got no response expected a DUT response (cycle %0d)", name, cyc);
   endtask

   function automatic int sat_inc(input int v, input int mx);
      return (v >= mx) ? mx : v + 1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string name);
      chk({name, "_outs"}, {imem_req, ir, pc_inc, pc_load, dmem_req, dmem_we, rf_we,
                            busy, halted, fault}, 32'd0);
      chk({name, "_retired"}, retired, 32'd0);
      chk({name, "_sat"}, {s_imem_req, s_busy, s_halted, s_fault, s_retired}, 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      imem_valid = 1'b0;
      dmem_ack = 1'b0;
      q.delete();
      mcnt = 0;
      mcnt2 = 0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic do_start();
      step();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // d < 0 means never acknowledge the data access.
   task automatic run_instr(input logic [8:0] x, input int iw, input int d, input bit tk);
      exp_t       e;
      int         n;
      logic [2:0] op;
      logic [1:0] f;
      bit         is_mem;
      op = x[8:6];
      f  = x[5:4];
      is_mem = (x != HALT_I) && (op == 3'd3) && (f == 2'd1 || f == 2'd2);
      n = 0;
      while (imem_req !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      if (imem_req !== 1'b1) begin
         fail_now("fetch_wait");
         return;
      end
      repeat (iw) step();
      instr = x;
      imem_valid = 1'b1;
      branch_taken = tk;
      e = '{default: 0};
      e.ins = x;
      if (x == HALT_I) begin
         e.halt = 1'b1;
         e.due = cyc + 2;
      end else if (is_mem) begin
         e.is_sw = (f == 2'd2);
         if (d < 0) begin
            e.halt = 1'b1;
            e.fault = 1'b1;
            e.due = cyc + 2 + MT;
         end else begin
            e.rf_we = (f == 2'd1);
            e.pc_inc = 1'b1;
            e.due = cyc + 2 + d + ((f == 2'd1) ? 1 : 0);
         end
      end else if (op == 3'd3 && f == 2'd3) begin
         e.pc_load = tk;
         e.pc_inc = !tk;
         e.due = cyc + 1;
      end else begin
         e.rf_we = 1'b1;
         e.pc_inc = 1'b1;
         e.due = cyc + 2;
      end
      if (!e.halt) begin
         mcnt = sat_inc(mcnt, MAXC);
         mcnt2 = sat_inc(mcnt2, 3);
      end
      e.ret = mcnt;
      e.ret2 = mcnt2;
      q.push_back(e);
      step();
      imem_valid = 1'b0;
      instr = 9'($urandom);
      if (is_mem) begin
         n = 0;
         while (dmem_req !== 1'b1 && n < 10) begin
            step();
            n++;
         end
         if (dmem_req !== 1'b1) begin
            fail_now("dmem_req_wait");
            return;
         end
         if (d < 0) begin
            repeat (MT + 2) step();
         end else begin
            repeat (d) step();
            dmem_ack = 1'b1;
            step();
            dmem_ack = 1'b0;
         end
      end else if (e.halt) begin
         repeat (2) step();
      end
   endtask

   function automatic logic [8:0] rand_instr();
      logic [2:0] op;
      logic [1:0] f;
      logic [8:0] x;
      int         r;
      r = $urandom_range(0, 9);
      op = 3'($urandom_range(0, 7));
      f = 2'($urandom_range(0, 3));
      if (r <= 3) begin
         if (op == 3'd3) op = 3'd1;
      end else begin
         op = 3'd3;
         case (r)
            4, 9:    f = 2'd0;
            5:       f = 2'd1;
            6:       f = 2'd2;
            default: f = 2'd3;
         endcase
      end
      x = {op, f, 4'($urandom)};
      if (x == HALT_I) x[0] = 1'b0;
      return x;
   endfunction

   task automatic check_start_ignored(input string name, input bit exp_fault);
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      chk({name, "_halted"}, {halted, busy, imem_req}, {1'b1, 1'b0, 1'b0});
      chk({name, "_fault"}, fault, exp_fault);
      chk({name, "_retired"}, retired, mcnt);
   endtask

   // Monitor: pops one expectation per completion strobe or halt entry.
   initial begin
      exp_t e;
      bit   pend = 0;
      int   pend_ret = 0;
      int   pend_ret2 = 0;
      bit   halted_q = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pend = 0;
            halted_q = 0;
         end else begin
            if (pend) begin
               chk("retired", retired, pend_ret);
               chk("retired_sat2", s_retired, pend_ret2);
               pend = 0;
            end
            if (pc_inc | pc_load) chk("pc_inc_pc_load_exclusive", pc_inc & pc_load, 0);
            if (rf_we | dmem_req) chk("rf_we_dmem_req_exclusive", rf_we & dmem_req, 0);
            if (dmem_req && q.size() > 0) begin
               chk("dmem_we", dmem_we, q[0].is_sw);
               chk("sat_dmem", {s_dmem_req, s_dmem_we}, {1'b1, q[0].is_sw});
            end
            if (pc_inc | pc_load | rf_we | (halted & !halted_q)) begin
               if (q.size() == 0) begin
                  fail_now("unexpected_event");
               end else begin
                  e = q.pop_front();
                  chk("strobes", {rf_we, pc_inc, pc_load, halted, fault},
                      {e.rf_we, e.pc_inc, e.pc_load, e.halt, e.fault});
                  chk("sat_strobes", {s_rf_we, s_pc_inc, s_pc_load, s_halted, s_fault},
                      {e.rf_we, e.pc_inc, e.pc_load, e.halt, e.fault});
                  chk("event_cycle", cyc, e.due);
                  chk("ir", {ir, s_ir}, {e.ins, e.ins});
                  pend = 1;
                  pend_ret = e.ret;
                  pend_ret2 = e.ret2;
               end
            end
            halted_q = halted;
         end
      end
   end

   initial begin
      int n;
      reset = 1'b1;
      start = 1'b0;
      instr = '0;
      imem_valid = 1'b0;
      dmem_ack = 1'b0;
      branch_taken = 1'b0;
      #1;
      chk_idle("reset_state");
      do_reset();

      // Directed programme.
      do_start();
      run_instr(9'b001_000_011, 0, 0, 1'b0);     // ARITH
      run_instr(9'b011_01_0000, 1, 2, 1'b0);     // LW, two wait cycles
      run_instr(9'b011_11_0101, 0, 0, 1'b1);     // BRANCH taken
      run_instr(9'b011_11_0101, 2, 0, 1'b0);     // BRANCH not taken
      run_instr(9'b011_10_0011, 0, 0, 1'b0);     // SW, zero wait
      run_instr(9'b011_00_1111, 0, 0, 1'b0);     // REDEF
      run_instr(9'b011_10_0001, 0, MT - 1, 1'b0); // SW ack on final timeout cycle
      run_instr(9'b011_01_0110, 0, MT - 1, 1'b1); // LW ack on final timeout cycle

      // Randomised programme.
      for (int i = 0; i < 150; i++) begin
         run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 4),
                   1'($urandom_range(0, 1)));
      end

      // Halt instruction: retired must not move, start must not restart.
      run_instr(HALT_I, 0, 0, 1'b0);
      check_start_ignored("halt_instr", 1'b0);

      // Reset while a load is waiting in MEM.
      do_reset();
      chk_idle("after_reset_from_halt");
      do_start();
      n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      instr = 9'b011_01_0010;
      imem_valid = 1'b1;
      step();
      imem_valid = 1'b0;
      step();
      chk("in_mem_before_reset", {dmem_req, dmem_we, busy}, {1'b1, 1'b0, 1'b1});
      reset = 1'b1;
      #1;
      chk_idle("reset_in_mem_async");
      step();
      chk_idle("reset_in_mem_next");
      reset = 1'b0;
      step();
      chk_idle("reset_in_mem_released");

      // Store that is never acknowledged.
      do_start();
      run_instr(9'b010_110_001, 0, 0, 1'b0);     // SHIFT
      run_instr(9'b011_10_1010, 0, -1, 1'b0);    // SW, no ack
      check_start_ignored("timeout", 1'b1);

      n = 0;
      while (q.size() > 0 && n < 50) begin
         step();
         n++;
      end
      if (q.size() > 0) fail_now("scoreboard_drain");
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
